// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared CSR map, bit positions and FSM encoding for irq_pending_ctrl
package irq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MISS   = 2'd2;
  localparam logic [1:0] ADDR_LAT    = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MASK_BIT  = 1;
  localparam int STAT_ACK_BIT   = 0;
  localparam int STAT_IRQ_BIT   = 16;
  localparam int STAT_STATE_LSB = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/irq_sat_counter.sv
// rtl/irq_sat_counter.sv - saturating up/down pending-event counter
module irq_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  logic full;
  logic dec_ok;
  logic inc_ok;

  // A decrement only happens on a nonzero count; at full an increment is
  // accepted only if a decrement frees a slot in the same cycle.
  assign full     = &count;
  assign dec_ok   = dec && (count != '0);
  assign inc_ok   = inc && (!full || dec_ok);
  assign overflow = inc && full && !dec_ok;

  // Count register: clear wins, simultaneous inc/dec nets to no change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + W'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending-event interrupt controller; optional latency capture under IRQ_LATENCY_EN
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int PEND_W  = 4,
  parameter int MISS_W  = 16,
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evt,
  output logic        irq,
  input  logic [1:0]  csr_addr,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  logic              enable;
  logic              mask;
  logic [PEND_W-1:0] pend;
  logic              pend_ovf;
  logic [MISS_W-1:0] miss;
  logic [31:0]       lat;
  irq_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       rd_mux;

  logic wr_ctrl;
  logic disable_wr;
  logic ack;
  logic miss_clr;
  logic evt_cnt;
  logic unused_wdata;

  assign wr_ctrl      = csr_write && (csr_addr == ADDR_CTRL);
  assign disable_wr   = wr_ctrl && !csr_writedata[CTRL_EN_BIT];
  assign ack          = csr_write && (csr_addr == ADDR_STATUS) && csr_writedata[STAT_ACK_BIT];
  assign miss_clr     = csr_write && (csr_addr == ADDR_MISS);
  assign evt_cnt      = enable && evt;
  assign unused_wdata = ^csr_writedata[31:2];

  irq_sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .clr      (disable_wr),
    .inc      (evt_cnt),
    .dec      (ack),
    .count    (pend),
    .overflow (pend_ovf)
  );

  // CTRL register: enable and mask bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      enable <= 1'b0;
      mask   <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= csr_writedata[CTRL_EN_BIT];
      mask   <= csr_writedata[CTRL_MASK_BIT];
    end
  end

  // Missed-event counter: events dropped at full pend, saturating, cleared by any write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      miss <= '0;
    end else if (miss_clr) begin
      miss <= '0;
    end else if (pend_ovf && !(&miss)) begin
      miss <= miss + MISS_W'(1);
    end
  end

  // Request FSM with registered irq; a HOLD->REQ return raises irq on the same
  // edge so the low gap between requests is exactly HOLDOFF cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      irq      <= 1'b0;
      hold_cnt <= '0;
    end else if (disable_wr) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          irq <= 1'b0;
          if ((pend != '0) && !mask) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mask) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end else if (ack) begin
            state    <= ST_HOLD;
            irq      <= 1'b0;
            hold_cnt <= HOLD_W'(HOLDOFF - 1);
          end else begin
            irq <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            if ((pend != '0) && !mask) begin
              state <= ST_REQ;
              irq   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              irq   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            irq      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_LATENCY_EN
  logic [31:0] lat_cnt;

  // Time the open request from irq rising; capture on the acknowledge that retires it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_cnt <= '0;
      lat     <= '0;
    end else begin
      lat_cnt <= irq ? sat_inc32(lat_cnt) : '0;
      if (ack && irq && (state == ST_REQ)) begin
        lat <= sat_inc32(lat_cnt);
      end
    end
  end
`else
  assign lat = '0;
`endif

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN_BIT]   = enable;
        rd_mux[CTRL_MASK_BIT] = mask;
      end
      ADDR_STATUS: begin
        rd_mux[PEND_W-1:0]          = pend;
        rd_mux[STAT_IRQ_BIT]        = irq;
        rd_mux[STAT_STATE_LSB +: 2] = state;
      end
      ADDR_MISS: begin
        rd_mux[MISS_W-1:0] = miss;
      end
      default: begin
        rd_mux = lat;
      end
    endcase
  end

  // Read data registered one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= rd_mux;
    end
  end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter PEND_W, default 4, width of the pending-event counter (depth 2^PEND_W-1).
REQ-002 SHALL have parameter MISS_W, default 16, width of the missed-event counter.
REQ-003 SHALL have parameter HOLDOFF, default 2, number of cycles irq is held low between consecutive requests.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port evt  input  1  one-cycle event pulse from the FPGA timer/counter.
REQ-007 SHALL have port irq  output  1  registered level interrupt request to the HPS.
REQ-008 SHALL have port csr_addr  input  2  register word address.
REQ-009 SHALL have port csr_write  input  1  write strobe.
REQ-010 SHALL have port csr_writedata  input  32  write data.
REQ-011 SHALL have port csr_read  input  1  read strobe.
REQ-012 SHALL have port csr_readdata  output  32  read data, valid the cycle after csr_read.

Function
REQ-013 SHALL map registers: 0 CTRL (bit0 enable, bit1 mask); 1 STATUS (bits PEND_W-1:0 pend, bit16 irq, bits 18:17 state); 2 MISS (MISS_W bits); 3 LAT (32 bits).
REQ-014 SHALL, when enable=1 and evt=1, increment pend by 1; when enable=0, ignore evt entirely.
REQ-015 SHALL, on evt while pend is at its maximum, hold pend and increment MISS, saturating at all-ones.
REQ-016 SHALL treat a write to STATUS with bit0=1 as an acknowledge: decrement pend by 1 if nonzero, else no effect.
REQ-017 SHALL, on a same-cycle counted evt and acknowledge, leave pend unchanged (net 0); at full, the evt counts and MISS is not incremented.
REQ-018 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-019 SHALL transition IDLE->REQ when pend>0 and mask=0, asserting irq one cycle later.
REQ-020 SHALL transition REQ->HOLD on acknowledge, deasserting irq on the next cycle.
REQ-021 SHALL stay in HOLD for exactly HOLDOFF cycles with irq=0, then go to REQ if pend>0 and mask=0, else IDLE.
REQ-022 SHALL, when mask=1 in REQ, deassert irq and return to IDLE; pend keeps counting.
REQ-023 SHALL clear MISS on any write to address 2.
REQ-024 SHALL clear pend and return to IDLE when enable is written 0.
REQ-025 SHALL return 0 for reads of unused bits; writes to STATUS bits other than bit0 and to LAT SHALL be ignored.

Reset
REQ-026 SHALL, while rst=0, set irq=0, csr_readdata=0, pend=0, MISS=0, LAT=0, CTRL=0 (disabled, unmasked), state=IDLE.
REQ-027 SHALL, on reset mid-request, drop irq on the next edge and discard pending events.

Configuration
REQ-028 SHALL, with IRQ_LATENCY_EN defined, count cycles from irq rising to acknowledge and load that count into LAT at acknowledge, saturating at 2^32-1.
REQ-029 SHALL, without IRQ_LATENCY_EN, omit the latency counter; LAT SHALL read 0.

Structure
REQ-030 SHALL place the register address constants, CTRL/STATUS bit positions and the FSM state encoding in shared package irq_pkg.
REQ-031 SHALL implement the saturating up/down pending counter as sub-module irq_sat_counter; the FSM and CSR logic SHALL stay in the top.

Verification
REQ-032 SHALL test: enable=1, one evt -> pend=1, irq=1 two cycles after evt; ack -> irq=0 next cycle, pend=0, state IDLE after HOLD.
REQ-033 SHALL test: 3 evts, then acks spaced 10 cycles apart -> three irq pulses, each followed by exactly 2 low cycles, ending with pend=0.
REQ-034 SHALL test: 17 evts with PEND_W=4 -> pend=15, MISS=2; write addr 2 -> MISS=0.
REQ-035 SHALL test: evt and ack in the same cycle with pend=1 -> pend stays 1, irq reasserts after HOLD.
REQ-036 SHALL test: with IRQ_LATENCY_EN, ack 25 cycles after irq rises -> LAT=25; without the macro -> LAT=0.
REQ-037 SHALL test: rst=0 while irq=1 and pend=5 -> irq=0 and pend=0 the next cycle; evt while enable=0 -> pend=0.
